// File: rtl/rbm_batch_controller_pkg.sv
// Shared types for the RBM batch sequencer: FSM encoding and a state classifier.
package rbm_batch_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_LAUNCH,
    S_RUN,
    S_ARGMAX,
    S_REPORT,
    S_DONE
  } state_e;

  function automatic logic is_busy(state_e s);
    return (s != S_IDLE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/rbm_batch_controller_if.sv
// Link between the batch controller and the RBM Main core.
interface rbm_batch_controller_if #(
  parameter int bitlength  = 12,
  parameter int output_dim = 10
);
  logic                            main_reset;
  logic                            main_data_valid;
  logic                            main_finish;
  logic [output_dim*bitlength-1:0] main_output_port;

  modport master (
    output main_reset, main_data_valid,
    input  main_finish, main_output_port
  );

  modport slave (
    input  main_reset, main_data_valid,
    output main_finish, main_output_port
  );
endinterface

// File: rtl/rbm_argmax_seq.sv
// Sequential signed argmax: latches a packed vector on load, scans one element per cycle.
// done/index are valid together in the final scan cycle; ties keep the lowest index.
module rbm_argmax_seq #(
  parameter int output_dim      = 10,
  parameter int bitlength       = 12,
  parameter int label_bitlength = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            load,
  input  logic [output_dim*bitlength-1:0] vec,
  output logic [label_bitlength-1:0]      index,
  output logic                            done
);

  localparam int IW = (output_dim > 1) ? $clog2(output_dim) : 1;
  localparam logic [IW-1:0] LAST = IW'(output_dim - 1);

  logic [output_dim*bitlength-1:0] vec_q, vec_d;
  logic signed [bitlength-1:0]     elems [output_dim];
  logic signed [bitlength-1:0]     best_q, best_d;
  logic [IW-1:0]                   cnt_q, cnt_d, best_idx_q, best_idx_d;
  logic                            run_q, run_d;
  logic                            take;

  for (genvar k = 0; k < output_dim; k++) begin : g_elem
    assign elems[k] = vec_q[k*bitlength +: bitlength];
  end

  // Element 0 seeds the running max unconditionally, so no sentinel value is needed.
  always_comb begin
    vec_d      = vec_q;
    best_d     = best_q;
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    run_d      = run_q;
    take       = (cnt_q == '0) || (elems[cnt_q] > best_q);
    if (load) begin
      vec_d = vec;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (take) begin
        best_d     = elems[cnt_q];
        best_idx_d = cnt_q;
      end
      if (cnt_q == LAST) run_d = 1'b0;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  assign done  = run_q && (cnt_q == LAST);
  assign index = label_bitlength'(take ? cnt_q : best_idx_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vec_q      <= '0;
      best_q     <= '0;
      cnt_q      <= '0;
      best_idx_q <= '0;
      run_q      <= 1'b0;
    end else begin
      vec_q      <= vec_d;
      best_q     <= best_d;
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      run_q      <= run_d;
    end
  end

endmodule

// File: rtl/rbm_batch_controller.sv
// Batch sequencer: runs Main once per stored image, classifies the output by argmax,
// scores it against the label and accumulates accuracy counters. All outputs registered.
module rbm_batch_controller
  import rbm_batch_controller_pkg::*;
#(
  parameter int bitlength       = 12,
  parameter int output_dim      = 10,
  parameter int image_num       = 100,
  parameter int index_bitlength = 7,
  parameter int label_bitlength = 4,
  parameter int count_bitlength = 16,
  parameter int rst_cycles      = 3,
  parameter int timeout_cycles  = 200000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic [index_bitlength-1:0] image_index,
  input  logic [label_bitlength-1:0] label,
  rbm_batch_controller_if.master     main,
  output logic [label_bitlength-1:0] predicted,
  output logic                       result_valid,
  output logic                       correct_flag,
  output logic [count_bitlength-1:0] correct_count,
  output logic [count_bitlength-1:0] image_count,
  output logic                       timeout_err,
  output logic                       busy,
  output logic                       done
);

  localparam int RC_W = (rst_cycles > 1) ? $clog2(rst_cycles) : 1;
  localparam int WD_W = $clog2(timeout_cycles + 1);

  state_e                     state_q, state_d;
  logic [RC_W-1:0]            rst_cnt_q, rst_cnt_d;
  logic [WD_W-1:0]            wdog_q, wdog_d;
  logic                       fin_prev_q, fin_prev_d;
  logic [index_bitlength-1:0] index_q, index_d;
  logic [label_bitlength-1:0] predicted_q, predicted_d;
  logic                       correct_flag_q, correct_flag_d;
  logic [count_bitlength-1:0] correct_count_q, correct_count_d;
  logic [count_bitlength-1:0] image_count_q, image_count_d;
  logic                       timeout_err_q, timeout_err_d;
  logic                       result_valid_q, result_valid_d;
  logic                       main_reset_q, main_reset_d;
  logic                       data_valid_q, data_valid_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       fin_edge;
  logic                       am_load;
  logic                       am_done;
  logic [label_bitlength-1:0] am_index;
  logic                       img_done;

  rbm_argmax_seq #(
    .output_dim     (output_dim),
    .bitlength      (bitlength),
    .label_bitlength(label_bitlength)
  ) u_argmax (
    .clock (clock),
    .reset (reset),
    .load  (am_load),
    .vec   (main.main_output_port),
    .index (am_index),
    .done  (am_done)
  );

  // fin_prev tracks finish in every state, so a level still high from the
  // previous image reaches RUN already "seen" and cannot fake an edge.
  assign fin_edge = main.main_finish & ~fin_prev_q;

  always_comb begin
    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    wdog_d          = wdog_q;
    fin_prev_d      = main.main_finish;
    index_d         = index_q;
    predicted_d     = predicted_q;
    correct_flag_d  = correct_flag_q;
    correct_count_d = correct_count_q;
    image_count_d   = image_count_q;
    timeout_err_d   = timeout_err_q;
    am_load         = 1'b0;
    img_done        = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          correct_count_d = '0;
          image_count_d   = '0;
          timeout_err_d   = 1'b0;
          index_d         = '0;
          rst_cnt_d       = '0;
          state_d         = S_RST;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RC_W'(rst_cycles - 1)) state_d = S_LAUNCH;
        else                                     rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A finish edge in the watchdog's last cycle still counts as a result.
        if (fin_edge) begin
          am_load = 1'b1;
          state_d = S_ARGMAX;
        end else if (wdog_q == WD_W'(timeout_cycles - 1)) begin
          timeout_err_d  = 1'b1;
          predicted_d    = '1;
          correct_flag_d = 1'b0;
          img_done       = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_ARGMAX: begin
        if (am_done) begin
          predicted_d    = am_index;
          correct_flag_d = (am_index == label);
          img_done       = 1'b1;
        end
      end
      S_REPORT: begin
        if (image_count_q == count_bitlength'(image_num)) begin
          state_d = S_DONE;
        end else begin
          index_d   = index_q + 1'b1;
          rst_cnt_d = '0;
          state_d   = S_RST;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Scoring lands with the REPORT entry so counters and result_valid appear together.
    if (img_done) begin
      state_d         = S_REPORT;
      image_count_d   = image_count_q + 1'b1;
      correct_count_d = correct_count_q + count_bitlength'(correct_flag_d);
    end

    result_valid_d = img_done;
    main_reset_d   = (state_d == S_RST);
    data_valid_d   = (state_d == S_RUN);
    busy_d         = is_busy(state_d);
    done_d         = (state_d == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      rst_cnt_q       <= '0;
      wdog_q          <= '0;
      fin_prev_q      <= 1'b0;
      index_q         <= '0;
      predicted_q     <= '0;
      correct_flag_q  <= 1'b0;
      correct_count_q <= '0;
      image_count_q   <= '0;
      timeout_err_q   <= 1'b0;
      result_valid_q  <= 1'b0;
      main_reset_q    <= 1'b0;
      data_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      wdog_q          <= wdog_d;
      fin_prev_q      <= fin_prev_d;
      index_q         <= index_d;
      predicted_q     <= predicted_d;
      correct_flag_q  <= correct_flag_d;
      correct_count_q <= correct_count_d;
      image_count_q   <= image_count_d;
      timeout_err_q   <= timeout_err_d;
      result_valid_q  <= result_valid_d;
      main_reset_q    <= main_reset_d;
      data_valid_q    <= data_valid_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign main.main_reset      = main_reset_q;
  assign main.main_data_valid = data_valid_q;
  assign image_index          = index_q;
  assign predicted            = predicted_q;
  assign result_valid         = result_valid_q;
  assign correct_flag         = correct_flag_q;
  assign correct_count        = correct_count_q;
  assign image_count          = image_count_q;
  assign timeout_err          = timeout_err_q;
  assign busy                 = busy_q;
  assign done                 = done_q;

endmodule

// File: tb/tb_rbm_batch_controller.sv
// Scoreboard bench: a behavioural Main stub answers after a per-image delay; expected
// per-image results are queued at batch start and popped on every result_valid.
module tb_rbm_batch_controller;

  localparam int BL = 12, OD = 10, IN = 5, IW = 3, LW = 4, CW = 8, RC = 3, TO = 60;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] image_index;
  logic [LW-1:0] label, predicted;
  logic          result_valid, correct_flag, timeout_err, busy, done;
  logic [CW-1:0] correct_count, image_count;

  rbm_batch_controller_if #(.bitlength(BL), .output_dim(OD)) m ();

  rbm_batch_controller #(
    .bitlength(BL), .output_dim(OD), .image_num(IN), .index_bitlength(IW),
    .label_bitlength(LW), .count_bitlength(CW), .rst_cycles(RC), .timeout_cycles(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .image_index(image_index),
    .label(label), .main(m), .predicted(predicted), .result_valid(result_valid),
    .correct_flag(correct_flag), .correct_count(correct_count),
    .image_count(image_count), .timeout_err(timeout_err), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Image/label ROM and per-image Main latency (0 = never finishes)
  logic [OD*BL-1:0] cur_vec [8];
  logic [LW-1:0]    cur_lbl [8];
  int               cur_dly [8];

  assign m.main_output_port = cur_vec[image_index];
  assign label              = cur_lbl[image_index];

  int stub_cnt;
  always @(posedge clock) begin
    if (reset || m.main_reset) begin
      stub_cnt      <= 0;
      m.main_finish <= 1'b0;
    end else if (m.main_data_valid && !m.main_finish) begin
      stub_cnt <= stub_cnt + 1;
      if (cur_dly[image_index] != 0 && stub_cnt + 1 == cur_dly[image_index])
        m.main_finish <= 1'b1;
    end
  end

  typedef struct {
    logic [LW-1:0] pred;
    logic          flag;
    int            cc, ic, idx, te, lat;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [LW-1:0] p, input logic f, input int cc, input int ic,
                      input int idx, input int te, input int lat);
    exp_t e;
    e.pred = p; e.flag = f; e.cc = cc; e.ic = ic; e.idx = idx; e.te = te; e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Monitor: main_reset pulse width, RST-entry-to-result latency, per-image results
  initial begin : monitor
    logic mr_prev;
    int   mr_run, lat;
    exp_t e;
    mr_prev = 1'b0; mr_run = 0; lat = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mr_prev = 1'b0; mr_run = 0; lat = 0;
      end else begin
        if (m.main_reset && !mr_prev) lat = 0;
        else                          lat++;
        if (m.main_reset) mr_run++;
        else if (mr_prev) begin
          check("main_reset_len", mr_run, RC);
          mr_run = 0;
        end
        mr_prev = m.main_reset;
        if (result_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got result_valid with predicted %0d, expected none", predicted);
          end else begin
            e = exp_q.pop_front();
            check("predicted",     predicted,     e.pred);
            check("correct_flag",  correct_flag,  e.flag);
            check("correct_count", correct_count, e.cc);
            check("image_count",   image_count,   e.ic);
            check("image_index",   image_index,   e.idx);
            check("timeout_err",   timeout_err,   e.te);
            check("latency",       lat,           e.lat);
          end
        end
      end
    end
  end

  task automatic set_elem(input int img, input int k, input int val);
    cur_vec[img][k*BL +: BL] = BL'(val);
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 2000) begin @(negedge clock); n++; end
    check(name, done, 1);
  endtask

  task automatic setup_b();
    int lbl [5] = '{3, 1, 4, 1, 5};
    int pk  [5] = '{3, 1, 0, 1, 5};
    int dl  [5] = '{5, 1, 20, 3, 10};
    for (int i = 0; i < 5; i++) begin
      cur_vec[i] = '0;
      set_elem(i, pk[i], 100);
      cur_lbl[i] = LW'(lbl[i]);
      cur_dly[i] = dl[i];
    end
  endtask

  task automatic push_b();
    push(4'd3, 1'b1, 1, 1, 0, 0, 20);
    push(4'd1, 1'b1, 2, 2, 1, 0, 16);
    push(4'd0, 1'b0, 2, 3, 2, 0, 35);
    push(4'd1, 1'b1, 3, 4, 3, 0, 18);
    push(4'd5, 1'b1, 4, 5, 4, 0, 25);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},          busy,              0);
    check({tag, "_done"},          done,              0);
    check({tag, "_predicted"},     predicted,         0);
    check({tag, "_result_valid"},  result_valid,      0);
    check({tag, "_correct_flag"},  correct_flag,      0);
    check({tag, "_correct_count"}, correct_count,     0);
    check({tag, "_image_count"},   image_count,       0);
    check({tag, "_timeout_err"},   timeout_err,       0);
    check({tag, "_image_index"},   image_index,       0);
    check({tag, "_main_reset"},    m.main_reset,      0);
    check({tag, "_data_valid"},    m.main_data_valid, 0);
  endtask

  initial begin : stim
    int neg [10] = '{-2048, -1000, -11, -500, -20, -2047, -100, -12, -300, -10};
    int mix [10] = '{100, -300, 50, 2047, 2047, -2048, 0, 1, 5, 2046};
    int n;
    for (int i = 0; i < 8; i++) begin cur_vec[i] = '0; cur_lbl[i] = '0; cur_dly[i] = 0; end

    repeat (3) @(negedge clock);
    check_idle_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Batch A: ramp, signed tie, all-negative, timeout, finish on the watchdog's last cycle
    for (int k = 0; k < OD; k++) begin
      set_elem(0, k, k * 10);
      set_elem(1, k, -5);
      set_elem(2, k, neg[k]);
      set_elem(4, k, mix[k]);
    end
    set_elem(0, 7, 200);
    set_elem(1, 2, 300);
    set_elem(1, 6, 300);
    cur_lbl[0] = 4'd7; cur_lbl[1] = 4'd6; cur_lbl[2] = 4'd9; cur_lbl[3] = 4'd3; cur_lbl[4] = 4'd3;
    cur_dly[0] = 50;   cur_dly[1] = 50;   cur_dly[2] = 50;   cur_dly[3] = 0;    cur_dly[4] = 59;
    push(4'd7, 1'b1, 1, 1, 0, 0, 65);
    push(4'd2, 1'b0, 1, 2, 1, 0, 65);
    push(4'd9, 1'b1, 2, 3, 2, 0, 65);
    push(4'hF, 1'b0, 2, 4, 3, 1, 64);
    push(4'd3, 1'b1, 3, 5, 4, 1, 74);
    pulse_start();
    wait_done("a_done_reached");
    check("a_busy",          busy,          0);
    check("a_correct_count", correct_count, 3);
    check("a_image_count",   image_count,   5);
    check("a_timeout_err",   timeout_err,   1);
    check("a_predicted",     predicted,     3);
    check("a_image_index",   image_index,   4);
    repeat (5) @(negedge clock);
    check("a_hold_count",    correct_count, 3);

    // Batch B from DONE, with a stray start while busy
    setup_b();
    push_b();
    pulse_start();
    n = 0;
    while (image_index != 3'd2 && n < 1000) begin @(negedge clock); n++; end
    check("b_reach_img2", image_index, 2);
    pulse_start();
    check("b_busy_after_start", busy, 1);
    wait_done("b_done_reached");
    check("b_correct_count", correct_count, 4);
    check("b_image_count",   image_count,   5);
    check("b_timeout_err",   timeout_err,   0);

    // Batch C: reset during ARGMAX of image 2, then a clean rerun
    push_b();
    pulse_start();
    n = 0;
    while (!(image_index == 3'd2 && m.main_data_valid) && n < 1000) begin @(negedge clock); n++; end
    check("c_reach_run2", m.main_data_valid, 1);
    n = 0;
    while (m.main_data_valid && n < 200) begin @(negedge clock); n++; end
    check("c_reach_argmax2", m.main_data_valid, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check_idle_zero("midrst");
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    push_b();
    pulse_start();
    wait_done("c_done_reached");
    check("c_correct_count", correct_count, 4);
    check("c_image_count",   image_count,   5);
    check("c_predicted",     predicted,     5);
    check("c_queue_empty",   exp_q.size(),  0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
